tw_mem_arbiter: RTL and testbench

TW_MEM_ARBITER -- requirements
Module: tw_mem_arbiter

---
 rtl/tw_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_tw_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tw_mem_arbiter.sv
// tw_mem_arbiter: two-requester lock arbiter for the taskwait memory.
// The cutoff (a) and taskwait (b) requesters each take a lock with x_req,
// hold it for a whole access sequence, and drive the memory while granted.
// Tie break favours whoever did not own the memory last.
// Optional feature: define TW_MEM_INIT_EN to zero-fill entries
// 0..NUM_ENTRIES-1 after reset before any grant is given.
module tw_mem_arbiter #(
    parameter int TW_MEM_BITS  = 4,
    parameter int TW_MEM_WIDTH = 101,
    parameter int NUM_ENTRIES  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    a_req,
    output logic                    a_gnt,
    input  logic                    a_en,
    input  logic                    a_we,
    input  logic [TW_MEM_BITS-1:0]  a_addr,
    input  logic [TW_MEM_WIDTH-1:0] a_din,
    input  logic                    b_req,
    output logic                    b_gnt,
    input  logic                    b_en,
    input  logic                    b_we,
    input  logic [TW_MEM_BITS-1:0]  b_addr,
    input  logic [TW_MEM_WIDTH-1:0] b_din,
    output logic [TW_MEM_WIDTH-1:0] rd_dout,
    output logic                    mem_clk,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [TW_MEM_BITS-1:0]  mem_addr,
    output logic [TW_MEM_WIDTH-1:0] mem_din,
    input  logic [TW_MEM_WIDTH-1:0] mem_dout,
    output logic                    init_done,
    output logic                    err
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_OWN_A = 2'd2;
    localparam logic [1:0] ST_OWN_B = 2'd3;

`ifdef TW_MEM_INIT_EN
    localparam logic [1:0] ST_RESET = ST_INIT;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    localparam logic [TW_MEM_BITS-1:0] LAST_ADDR = TW_MEM_BITS'(NUM_ENTRIES - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_last_b;      // 1: last owner was b
    logic [TW_MEM_BITS-1:0]  r_init_cnt;
    logic                    r_err;
    logic                    w_mem_en;
    logic                    w_mem_we;
    logic                    w_viol;

    // Next-state selection: zero-fill sweep, arbitration, hand-over on release
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == LAST_ADDR) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (a_req && b_req)  w_state_nxt = r_last_b ? ST_OWN_A : ST_OWN_B;
                else if (a_req)      w_state_nxt = ST_OWN_A;
                else if (b_req)      w_state_nxt = ST_OWN_B;
            end
            ST_OWN_A: begin
                if (!a_req) w_state_nxt = b_req ? ST_OWN_B : ST_IDLE;
            end
            ST_OWN_B: begin
                if (!b_req) w_state_nxt = a_req ? ST_OWN_A : ST_IDLE;
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    // State register, last-owner tracking and zero-fill address counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_RESET;
            r_last_b   <= 1'b1;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_OWN_A && !a_req) r_last_b <= 1'b0;
            if (r_state == ST_OWN_B && !b_req) r_last_b <= 1'b1;
            if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    assign a_gnt = (r_state == ST_OWN_A);
    assign b_gnt = (r_state == ST_OWN_B);

    // An enable from a requester that does not hold the lock is a protocol error
    assign w_viol = (a_en && !a_gnt) || (b_en && !b_gnt);

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rstn)       r_err <= 1'b0;
        else if (w_viol) r_err <= 1'b1;
    end

    assign err = r_err;

    // Memory port mux: sweep writes during INIT, owner's signals otherwise
    always_comb begin
        w_mem_en = 1'b0;
        w_mem_we = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (r_state)
            ST_INIT: begin
                w_mem_en = 1'b1;
                w_mem_we = 1'b1;
                mem_addr = r_init_cnt;
            end
            ST_OWN_A: begin
                w_mem_en = a_en;
                w_mem_we = a_we;
                mem_addr = a_addr;
                mem_din  = a_din;
            end
            ST_OWN_B: begin
                w_mem_en = b_en;
                w_mem_we = b_we;
                mem_addr = b_addr;
                mem_din  = b_din;
            end
            default: ;
        endcase
    end

    // Reset masks the strobes combinationally so nothing reaches memory
    // in the reset cycle, even before the state register has been cleared.
    assign mem_en    = w_mem_en & rstn;
    assign mem_we    = w_mem_we & rstn;
    assign mem_clk   = clk;
    assign rd_dout   = mem_dout;
    assign init_done = (r_state != ST_INIT);

endmodule

// File: tb/tb_tw_mem_arbiter.sv
// Directed bench for tw_mem_arbiter with a 1-cycle-latency memory model.
// Covers reset, single grant, tie breaks, hand-over, non-owner access,
// reset mid-sequence and back-to-back re-request; the TW_MEM_INIT_EN
// build additionally checks the zero-fill sweep.
module tb_tw_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 101;
    localparam int NE = 16;

    localparam logic [DW-1:0] D3 = {37'h1_2345_6789, 64'hDEAD_BEEF_CAFE_F00D};
    localparam logic [DW-1:0] D5 = {37'h0_0F0F_F0F0, 64'h0123_4567_89AB_CDEF};
    localparam logic [DW-1:0] DB = {37'h1_FFFF_FFFF, 64'hFFFF_0000_FFFF_0000};

    logic          clk = 1'b0;
    logic          rstn;
    logic          a_req, a_en, a_we, b_req, b_en, b_we;
    logic          a_gnt, b_gnt;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_din, b_din, rd_dout, mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_clk, mem_en, mem_we, init_done, err;

    logic [DW-1:0] mem [NE];

    int checks = 0;
    int errors = 0;

    tw_mem_arbiter #(
        .TW_MEM_BITS  (AW),
        .TW_MEM_WIDTH (DW),
        .NUM_ENTRIES  (NE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .a_req     (a_req),
        .a_gnt     (a_gnt),
        .a_en      (a_en),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_din     (a_din),
        .b_req     (b_req),
        .b_gnt     (b_gnt),
        .b_en      (b_en),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_din     (b_din),
        .rd_dout   (rd_dout),
        .mem_clk   (mem_clk),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .init_done (init_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after the access
    always @(posedge mem_clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout <= mem[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One reset cycle; returns in the first cycle in which requests are served
    task automatic do_reset();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
`ifdef TW_MEM_INIT_EN
        repeat (NE) cyc();
`endif
    endtask

    initial begin
        mem_dout = '0;
        rstn = 1'b0;
        a_req = 1'b0; a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_req = 1'b0; b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        cyc();
        cyc();
        #1;
        chk1("rst_a_gnt", a_gnt, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);

`ifdef TW_MEM_INIT_EN
        // Zero-fill sweep, with a request held off from cycle 2
        rstn = 1'b1;
        for (int i = 0; i < NE; i++) begin
            if (i == 2) a_req = 1'b1;
            #1;
            chk1("init_done_low", init_done, 1'b0);
            chk1("init_mem_en", mem_en, 1'b1);
            chk1("init_mem_we", mem_we, 1'b1);
            chka("init_addr", mem_addr, AW'(i));
            chkd("init_din", mem_din, '0);
            chk1("init_no_gnt", a_gnt, 1'b0);
            cyc();
        end
        #1;
        chk1("init_done_high", init_done, 1'b1);
        chk1("init_gnt_c16", a_gnt, 1'b0);
        cyc();
        chk1("init_gnt_c17", a_gnt, 1'b1);
        a_req = 1'b0;
        // Reset mid-sweep restarts at address 0
        do_reset();
        rstn = 1'b0;
        repeat (3) cyc();
        rstn = 1'b1;
        repeat (5) cyc();
        #1;
        chka("init_mid_addr5", mem_addr, 4'd5);
        rstn = 1'b0;
        #1;
        chk1("init_rst_mem_en", mem_en, 1'b0);
        cyc();
        rstn = 1'b1;
        #1;
        chka("init_restart_addr", mem_addr, 4'd0);
        chk1("init_restart_done", init_done, 1'b0);
        repeat (NE) cyc();
`else
        rstn = 1'b1;
`endif
        do_reset();
        #1;
        chk1("init_done", init_done, 1'b1);
        chk1("idle_a_gnt", a_gnt, 1'b0);
        chk1("idle_mem_en", mem_en, 1'b0);

        // Single request: 1-cycle grant latency, writes then reads via a
        a_req = 1'b1;
        #1;
        chk1("single_gnt_lat", a_gnt, 1'b0);
        cyc();
        chk1("single_a_gnt", a_gnt, 1'b1);
        chk1("single_b_gnt", b_gnt, 1'b0);
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_din = D3;
        #1;
        chk1("wr_mem_en", mem_en, 1'b1);
        chk1("wr_mem_we", mem_we, 1'b1);
        chka("wr_mem_addr", mem_addr, 4'd3);
        chkd("wr_mem_din", mem_din, D3);
        cyc();
        a_addr = 4'd5; a_din = D5;
        cyc();
        a_we = 1'b0; a_addr = 4'd5;
        cyc();
        chkd("rd_addr5", rd_dout, D5);
        // Read issued in the release cycle still returns data afterwards
        a_addr = 4'd3; a_req = 1'b0;
        cyc();
        a_en = 1'b0;
        #1;
        chk1("rel_a_gnt", a_gnt, 1'b0);
        chkd("rd_after_release", rd_dout, D3);
        chk1("rel_mem_en", mem_en, 1'b0);

        // Tie after reset goes to a; release hands straight to b
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        cyc();
        chk1("tie1_a_gnt", a_gnt, 1'b1);
        chk1("tie1_b_gnt", b_gnt, 1'b0);
        a_req = 1'b0;
        cyc();
        chk1("handover_b_gnt", b_gnt, 1'b1);
        chk1("handover_a_gnt", a_gnt, 1'b0);
        b_req = 1'b0;
        cyc();
        chk1("b_rel_idle", b_gnt, 1'b0);
        a_req = 1'b1; b_req = 1'b1;
        cyc();
        chk1("tie2_a_gnt", a_gnt, 1'b1);
        a_req = 1'b0; b_req = 1'b0;
        cyc();
        chk1("a_rel_idle", a_gnt, 1'b0);
        a_req = 1'b1; b_req = 1'b1;
        cyc();
        chk1("tie3_b_gnt", b_gnt, 1'b1);
        chk1("tie3_a_gnt", a_gnt, 1'b0);
        repeat (3) cyc();
        chk1("no_preempt", b_gnt, 1'b1);
        a_req = 1'b0; b_req = 1'b0;
        cyc();
        chk1("err_clean", err, 1'b0);

        // Non-owner access: b strobes while a owns
        a_req = 1'b1;
        cyc();
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd5;
        b_en = 1'b1; b_we = 1'b1; b_addr = 4'd9; b_din = DB;
        #1;
        chk1("nonown_mem_we", mem_we, 1'b0);
        chka("nonown_mem_addr", mem_addr, 4'd5);
        chk1("nonown_err_pre", err, 1'b0);
        cyc();
        b_en = 1'b0; b_we = 1'b0;
        #1;
        chk1("nonown_err", err, 1'b1);
        chkd("nonown_rd", rd_dout, D5);
        repeat (3) cyc();
        chk1("err_sticky", err, 1'b1);
        a_en = 1'b0; a_req = 1'b0;
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        #1;
        chk1("err_cleared", err, 1'b0);
`ifdef TW_MEM_INIT_EN
        repeat (NE) cyc();
`endif

        // Reset while b owns and is accessing
        b_req = 1'b1;
        cyc();
        chk1("pre_rst_b_gnt", b_gnt, 1'b1);
        b_en = 1'b1; b_addr = 4'd3;
        rstn = 1'b0;
        #1;
        chk1("rst_mid_mem_en", mem_en, 1'b0);
        cyc();
        b_en = 1'b0;
        rstn = 1'b1;
        #1;
        chk1("rst_mid_b_gnt", b_gnt, 1'b0);
`ifdef TW_MEM_INIT_EN
        chka("rst_mid_init_addr", mem_addr, 4'd0);
        repeat (NE) cyc();
`endif
        cyc();
        chk1("post_rst_b_gnt", b_gnt, 1'b1);
        b_req = 1'b0;
        cyc();

        // Back-to-back: release then immediate re-request passes through IDLE
        a_req = 1'b1;
        cyc();
        chk1("b2b_first_gnt", a_gnt, 1'b1);
        a_req = 1'b0;
        cyc();
        chk1("b2b_idle", a_gnt, 1'b0);
        a_req = 1'b1;
        #1;
        chk1("b2b_still_idle", a_gnt, 1'b0);
        cyc();
        chk1("b2b_regrant", a_gnt, 1'b1);
        chk1("b2b_err", err, 1'b0);
        a_req = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
